// File: rtl/if_fetch_unit.sv
// Instruction-fetch control between the PC register and decode.
// Build option: define IF_PERF_CNT_EN to add the perf_fetched / perf_wait_cycles counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic [31:0] pc_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_id,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic        icache_rvalid,
    input  logic [31:0] icache_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        kill;
    logic        kill_nxt;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    logic        ifid_free;
    logic        redir;
    logic        rsp_ok;
    logic        load_fetch;
    logic        load_hold;
    logic        capture_hold;

    // A redirect outranks every other event; responses for killed fetches are never used.
    assign ifid_free    = !ifid_valid || !stall_id;
    assign redir        = redirect_valid && (state != IDLE);
    assign rsp_ok       = (state == WAIT) && icache_rvalid && !kill && !redirect_valid;
    assign load_fetch   = rsp_ok && ifid_free;
    assign capture_hold = rsp_ok && !ifid_free;
    assign load_hold    = (state == HOLD) && !stall_id && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (!redirect_valid && icache_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (icache_rvalid) begin
                    kill_nxt  = 1'b0;
                    state_nxt = capture_hold ? HOLD : REQ;
                end else if (redirect_valid) begin
                    kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || !stall_id)
                    state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_en       = redir || load_fetch || load_hold;
        pc_next     = redirect_valid ? redirect_pc : pc + 32'd4;
        icache_req  = (state == REQ) && !redirect_valid;
        icache_addr = pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pc    <= '0;
            hold_instr <= '0;
        end else if (capture_hold) begin
            hold_pc    <= pc;
            hold_instr <= icache_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= RESET_INSTR;
        end else if (redir) begin
            ifid_valid <= 1'b0;
            ifid_instr <= RESET_INSTR;
        end else if (load_fetch) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc;
            ifid_instr <= icache_rdata;
        end else if (load_hold) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= hold_pc;
            ifid_instr <= hold_instr;
        end else if (ifid_valid && !stall_id) begin
            ifid_valid <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched     <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (load_fetch || load_hold)
                perf_fetched <= perf_fetched + 32'd1;
            if (state == WAIT || state == HOLD)
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed steps, then random traffic checked against
// a program-order model of the instruction stream delivered to decode.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall_id = 1'b0;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready = 1'b0;
    logic        icache_rvalid = 1'b0;
    logic [31:0] icache_rdata = '0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_wait_cycles;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] pc_rst_val = '0;
    int          resp_cnt = -1;
    logic [31:0] resp_addr = '0;
    int          lat_min = 1;
    int          lat_max = 1;

    logic [31:0] exp_pc = '0;
    int          consumed = 0;
    int          loads = 0;
    logic        prev_load = 1'b0;
    logic [31:0] prev_load_pc = '0;
    logic        prev_redir = 1'b0;

    if_fetch_unit #(.RESET_INSTR(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_en          (pc_en),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_id       (stall_id),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_ready   (icache_ready),
        .icache_rvalid  (icache_rvalid),
        .icache_rdata   (icache_rdata),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    // PC register fed by the unit
    always @(posedge clk or posedge rst) begin
        if (rst)
            pc <= pc_rst_val;
        else if (pc_en)
            pc <= pc_next;
    end

    // Instruction image: addi x(n&31), x0, n with n = addr/4 + 1, upper bits salted by address
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        logic [31:0] n;
        n = (a >> 2) + 32'd1;
        return {n[11:0] ^ a[31:20], 8'd0, n[4:0], 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply_reset(input logic [31:0] start_pc);
        @(negedge clk);
        pc_rst_val     = start_pc;
        stall_id       = 1'b0;
        redirect_valid = 1'b0;
        icache_ready   = 1'b0;
        icache_rvalid  = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_ifid_valid", ifid_valid, 0);
        chk("rst_ifid_pc", ifid_pc, 0);
        chk("rst_ifid_instr", ifid_instr, NOP);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_icache_req", icache_req, 0);
        chk("rst_icache_addr", icache_addr, start_pc);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_wait", perf_wait_cycles, 0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        exp_pc     = start_pc;
        resp_cnt   = -1;
        prev_load  = 1'b0;
        prev_redir = 1'b0;
        loads      = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, settle, check, update models.
    task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc,
                         input logic rdy);
        @(negedge clk);
        stall_id       = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        icache_ready   = rdy;
        if (resp_cnt == 0) begin
            icache_rvalid = 1'b1;
            icache_rdata  = instr_of(resp_addr);
            resp_cnt      = -1;
        end else begin
            icache_rvalid = 1'b0;
            icache_rdata  = $urandom;
            if (resp_cnt > 0)
                resp_cnt--;
        end
        #1;
        chk("icache_addr", icache_addr, pc);
        chk("pc_next", pc_next, redir ? rpc : pc + 32'd4);
        if (prev_redir) begin
            chk("flush_valid", ifid_valid, 0);
            chk("flush_instr", ifid_instr, NOP);
        end else if (prev_load) begin
            chk("load_valid", ifid_valid, 1);
            chk("load_pc", ifid_pc, prev_load_pc);
        end
        if (redir) begin
            chk("redir_pc_en", pc_en, 1);
            chk("redir_req", icache_req, 0);
        end
        if (resp_cnt >= 0 || icache_rvalid)
            chk("req_while_busy", icache_req, 0);
        if (ifid_valid === 1'b1 && !stall) begin
            chk("stream_pc", ifid_pc, exp_pc);
            chk("stream_instr", ifid_instr, instr_of(exp_pc));
            exp_pc += 32'd4;
            consumed++;
        end
        if (redir)
            exp_pc = rpc;
        prev_load    = (pc_en === 1'b1) && !redir;
        prev_load_pc = pc;
        if (prev_load)
            loads++;
        prev_redir = redir;
        if (icache_req === 1'b1 && rdy) begin
            resp_addr = icache_addr;
            resp_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;

        // Zero-wait cache from pc=0
        apply_reset(32'h0);
        cycle(0, 0, 0, 1);
        chk("idle_req", icache_req, 0);
        chk("idle_pc_en", pc_en, 0);
        cycle(0, 0, 0, 1);
        chk("c1_req", icache_req, 1);
        chk("c1_pc_en", pc_en, 0);
        cycle(0, 0, 0, 1);
        chk("c2_pc_en", pc_en, 1);
        chk("c2_pc_next", pc_next, 32'h4);
        cycle(0, 0, 0, 1);
        chk("c3_ifid_valid", ifid_valid, 1);
        chk("c3_ifid_pc", ifid_pc, 32'h0);
        chk("c3_ifid_instr", ifid_instr, 32'h00100093);
        chk("c3_pc_en", pc_en, 0);
        chk("c3_req", icache_req, 1);
        cycle(0, 0, 0, 1);
        chk("c4_pc_en", pc_en, 1);
        chk("c4_pc_next", pc_next, 32'h8);

        // Decode stall while a response arrives
        cycle(1, 0, 0, 1);
        chk("c5_ifid_pc", ifid_pc, 32'h4);
        chk("c5_ifid_instr", ifid_instr, 32'h00200113);
        cycle(1, 0, 0, 1);
        chk("c6_pc_en", pc_en, 0);
        cycle(1, 0, 0, 1);
        chk("c7_pc_en", pc_en, 0);
        chk("c7_req", icache_req, 0);
        cycle(1, 0, 0, 1);
        chk("c8_pc_en", pc_en, 0);
        chk("c8_ifid_pc", ifid_pc, 32'h4);
        cycle(0, 0, 0, 1);
        chk("c9_pc_en", pc_en, 1);
        chk("c9_pc_next", pc_next, 32'hC);
        lat_min = 3;
        lat_max = 3;
        cycle(0, 0, 0, 1);
        chk("c10_ifid_pc", ifid_pc, 32'h8);
        chk("c10_ifid_instr", ifid_instr, instr_of(32'h8));
        chk("c10_req", icache_req, 1);

        // Redirect while a fetch is outstanding
        cycle(0, 1, 32'h80, 1);
        chk("c11_pc_en", pc_en, 1);
        chk("c11_pc_next", pc_next, 32'h80);
        lat_min = 1;
        lat_max = 1;
        cycle(0, 0, 0, 1);
        chk("c12_req", icache_req, 0);
        chk("c12_pc_en", pc_en, 0);
        cycle(0, 0, 0, 1);
        chk("c13_stale_pc_en", pc_en, 0);
        chk("c13_ifid_valid", ifid_valid, 0);
        cycle(0, 0, 0, 1);
        chk("c14_req", icache_req, 1);
        chk("c14_addr", icache_addr, 32'h80);
        cycle(0, 0, 0, 1);
        chk("c15_pc_en", pc_en, 1);
        chk("c15_pc_next", pc_next, 32'h84);
        cycle(0, 0, 0, 1);
        chk("c16_ifid_pc", ifid_pc, 32'h80);

        // Redirect coinciding with the response
        cycle(0, 1, 32'h200, 1);
        chk("c17_pc_en", pc_en, 1);
        chk("c17_pc_next", pc_next, 32'h200);
        cycle(0, 0, 0, 1);
        chk("c18_ifid_valid", ifid_valid, 0);
        chk("c18_ifid_instr", ifid_instr, NOP);
        chk("c18_req", icache_req, 1);
        chk("c18_addr", icache_addr, 32'h200);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h300, 1);
        chk("c20_req", icache_req, 0);
        cycle(0, 0, 0, 1);
        chk("c21_req", icache_req, 1);
        chk("c21_addr", icache_addr, 32'h300);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // Address wrap, then reset in the middle of WAIT
        apply_reset(32'hFFFF_FFFC);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("w_addr", icache_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 1);
        chk("w_pc_en", pc_en, 1);
        chk("w_pc_next", pc_next, 32'h0);
        lat_min = 3;
        lat_max = 3;
        cycle(1, 0, 0, 1);
        chk("w_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("w_ifid_instr", ifid_instr, instr_of(32'hFFFF_FFFC));
        chk("w_addr0", icache_addr, 32'h0);
        cycle(1, 0, 0, 1);
        chk("w_pre_rst_valid", ifid_valid, 1);
        apply_reset(32'h0);
        lat_min  = 1;
        lat_max  = 1;
        resp_cnt = 0;
        cycle(0, 0, 0, 1);
        chk("r_idle_pc_en", pc_en, 0);
        chk("r_idle_req", icache_req, 0);
        cycle(0, 0, 0, 1);
        chk("r_ifid_valid", ifid_valid, 0);
        chk("r_req", icache_req, 1);
        chk("r_addr", icache_addr, 32'h0);
        cycle(0, 0, 0, 1);
        chk("r_pc_en", pc_en, 1);
        chk("r_pc_next", pc_next, 32'h4);

        // Random traffic
        lat_min = 1;
        lat_max = 4;
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            logic        st;
            logic        rd;
            logic        rdy;
            logic [31:0] tgt;
            st  = ($urandom_range(9, 0) < 3);
            rd  = ($urandom_range(99, 0) < 4);
            rdy = ($urandom_range(9, 0) < 7);
            tgt = $urandom & 32'hFFFF_FFFC;
            cycle(st, rd, tgt, rdy);
        end
        chk("liveness", 32'((consumed - c0) > 200), 32'd1);
`ifdef IF_PERF_CNT_EN
        @(negedge clk);
        chk("perf_fetched", perf_fetched, 32'(loads));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch control stage that sits directly between the program-counter register and the decode stage. It issues the current `pc` to the instruction cache, waits for the returned word, and loads the IF/ID pipeline register. It then drives `pc_next`/`pc_en` back into the PC register. Branch redirects from EX and decode back-pressure are absorbed here, so the PC advances exactly once per delivered or redirected instruction.

## Interface
Parameters:
- `RESET_INSTR`, default 32'h00000013, value of `ifid_instr` after reset or flush (RV32I NOP).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current PC from the PC register.
- `pc_en`  out  1  PC register update enable.
- `pc_next`  out  32  next PC value.
- `redirect_valid`  in  1  taken branch/jump from EX; single-cycle pulse.
- `redirect_pc`  in  32  redirect target.
- `stall_id`  in  1  decode cannot accept a new instruction this cycle.
- `icache_req`  out  1  fetch request valid.
- `icache_addr`  out  32  fetch address.
- `icache_ready`  in  1  cache accepts request this cycle.
- `icache_rvalid`  in  1  returned instruction valid; exactly one per accepted request.
- `icache_rdata`  in  32  returned instruction.
- `ifid_valid`  out  1  IF/ID register holds a live instruction.
- `ifid_pc`  out  32  PC of that instruction.
- `ifid_instr`  out  32  the instruction.

## Operation
- The FSM has four states: IDLE, REQ, WAIT and HOLD. Registers: `kill` flag, hold buffer (pc + instr), IF/ID register.
- Reset (async) sets the following: state=IDLE, kill=0, hold empty, `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=RESET_INSTR. Combinational outputs are then `pc_en`=0, `icache_req`=0, `icache_addr`=`pc`.
- IDLE moves to REQ unconditionally on the next edge.
- REQ
  - `icache_req`=!`redirect_valid`; `icache_addr`=`pc`.
  - If `icache_ready` is high with the request asserted, go to WAIT.
  - A request is held until accepted, except that it is withdrawn in any redirect cycle.
- WAIT
  - `icache_rvalid` with kill=1 or `redirect_valid`: drop the data, clear kill, go to REQ.
  - `icache_rvalid` with the IF/ID register free (`!ifid_valid || !stall_id`): load IF/ID with {`pc`, `icache_rdata`}, assert `pc_en`, go to REQ.
  - `icache_rvalid` with the IF/ID register occupied: capture into the hold buffer, go to HOLD. `pc_en` stays 0.
  - `redirect_valid` without `icache_rvalid`: set kill and stay in WAIT.
- HOLD
  - On `!stall_id`: move the hold buffer into IF/ID, assert `pc_en`, go to REQ.
  - On `redirect_valid`: discard the hold buffer and go to REQ.
- Redirect, in any state except IDLE:
  - `pc_en`=1 and `pc_next`=`redirect_pc`.
  - `ifid_valid` is cleared on the next edge and `ifid_instr` is set to RESET_INSTR.
  - Redirect has priority over every other event in the same cycle.
- `pc_next` = `redirect_valid` ? `redirect_pc` : `pc`+32'd4. The add wraps modulo 2^32; 32'hFFFFFFFC+4 gives 0.
- IF/ID consumption: the instruction is consumed when `ifid_valid && !stall_id`. `ifid_valid` drops after consumption if nothing new loads in the same cycle.
- `pc_en` is asserted at most once per delivered instruction or redirect, and never in IDLE.

## Timing
- With a zero-wait cache (`icache_ready`=1, `rvalid` one cycle after acceptance), the sequence is REQ→WAIT→REQ: one instruction every 2 cycles.
- `ifid_valid` rises on the edge that ends the WAIT cycle with `rvalid`.
- `pc` shows `pc`+4 one cycle after the `pc_en` cycle, so the following REQ fetches the new address.
- Redirect-to-first-request latency is 1 cycle when idle in REQ. When a fetch is outstanding, the new request waits for the killed response.
- All outputs are either registered or combinational from state and inputs. There are no combinational paths from `icache_rdata` to `pc_en`.
- Reset mid-operation: any `icache_rvalid` arriving after reset is ignored, because data is sampled only in WAIT.

## Configuration
- `IF_PERF_CNT_EN`
  - Defined: adds output ports `perf_fetched` (32) and `perf_wait_cycles` (32), both reset to 0 and wrapping at 2^32.
  - `perf_fetched` increments on every IF/ID load.
  - `perf_wait_cycles` increments on every cycle spent in WAIT or HOLD.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset with `pc`=0, zero-wait cache returning 0x00100093 then 0x00200113. Required: `ifid_pc`=0 then 4 with the matching instructions, `pc_en` pulsed once per 2 cycles, `pc_next`=4 then 8.
- `stall_id` held for 3 cycles while IF/ID is full and a response arrives. Required: FSM in HOLD, `pc_en`=0 throughout, instruction delivered after the stall with PC correct, no word lost or duplicated.
- `redirect_valid` with `redirect_pc`=0x80 while in WAIT, `rvalid` 2 cycles later. Required: `pc_en`=1 with `pc_next`=0x80, stale response dropped, next `icache_addr`=0x80, `ifid_valid`=0 meanwhile.
- `redirect_valid` in the same cycle as `icache_rvalid`. Required: data dropped, `ifid_instr`=0x00000013 and `ifid_valid`=0 next cycle, next request at the target.
- `pc`=0xFFFFFFFC fetch completes. Required: `pc_next`=0. Also, `rst` asserted mid-WAIT gives `ifid_valid`=0, state IDLE, and the counters (if `IF_PERF_CNT_EN`) at 0 immediately.
